// File: rtl/irq_requester_pkg.sv
// Shared types and default constants for the device-side IRQ/EOI requester.
package irq_requester_pkg;

  typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

  localparam int NUM_IRQ_DEF     = 16;
  localparam int CNT_W_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int MIN_LOW_DEF     = 2;
  localparam int TIMEOUT_DEF     = 1024;
  localparam int TMO_W_DEF       = $clog2(TIMEOUT_DEF + 1);

endpackage

// File: rtl/irq_req_chan.sv
// One IRQ/EOI channel: EOI synchronizer, pending-event counter, request FSM,
// timeout/gap timers and sticky status flags.
module irq_req_chan
  import irq_requester_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int MIN_LOW     = MIN_LOW_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             event_i,
  input  logic             mask_i,
  input  logic             eoi_i,
  input  logic             clr_i,
  output logic             irq_o,
  output logic [CNT_W-1:0] pend_cnt_o,
  output logic             overflow_o,
  output logic             timeout_o,
  output logic             spurious_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (MIN_LOW > 1) ? $clog2(MIN_LOW) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_LOW - 1);

  function automatic logic [TMO_W-1:0] tmo_inc(input logic [TMO_W-1:0] t);
    return (t == TMO_LIM) ? t : t + TMO_W'(1);
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   eoi_prev_q;
  logic                   eoi_edge;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [TMO_W-1:0] tmo_q, tmo_nxt;
  logic [GAP_W-1:0] gap_q, gap_nxt;
  logic             irq_q;
  logic             ovf_q, tmo_flag_q, spur_q;
  logic             accept, ovf_set, tmo_set, spur_set;

  // Synchronizer presets to 1 so an EOI held across reset release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '1;
      eoi_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], eoi_i};
      eoi_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign eoi_edge = sync_q[SYNC_STAGES-1] & ~eoi_prev_q;

  always_comb begin
    state_nxt = state_q;
    tmo_nxt   = '0;
    gap_nxt   = '0;
    accept    = 1'b0;
    tmo_set   = 1'b0;
    case (state_q)
      IDLE: if (cnt_q != '0 && !mask_i) state_nxt = ASSERT;
      ASSERT: begin
        if (eoi_edge) begin
          accept    = 1'b1;
          state_nxt = GAP;
        end else begin
          tmo_nxt = tmo_inc(tmo_q);
          tmo_set = (tmo_nxt == TMO_LIM);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_nxt = IDLE;
        else                   gap_nxt   = gap_q + GAP_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
    spur_set = eoi_edge && (state_q != ASSERT);

    // Simultaneous event and acceptance cancel; a saturated counter drops the event.
    cnt_nxt = cnt_q;
    ovf_set = 1'b0;
    if (event_i && !accept) begin
      if (cnt_q == CNT_MAX) ovf_set = 1'b1;
      else                  cnt_nxt = cnt_q + CNT_W'(1);
    end else if (accept && !event_i) begin
      cnt_nxt = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tmo_q      <= '0;
      gap_q      <= '0;
      irq_q      <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_flag_q <= 1'b0;
      spur_q     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      cnt_q      <= cnt_nxt;
      tmo_q      <= tmo_nxt;
      gap_q      <= gap_nxt;
      irq_q      <= (state_nxt == ASSERT);
      ovf_q      <= ovf_set  | (ovf_q      & ~clr_i);
      tmo_flag_q <= tmo_set  | (tmo_flag_q & ~clr_i);
      spur_q     <= spur_set | (spur_q     & ~clr_i);
    end
  end

  assign irq_o      = irq_q;
  assign pend_cnt_o = cnt_q;
  assign overflow_o = ovf_q;
  assign timeout_o  = tmo_flag_q;
  assign spurious_o = spur_q;

endmodule

// File: rtl/irq_requester.sv
// Device-side IRQ/EOI pad interface: NUM_IRQ independent request channels.
module irq_requester
  import irq_requester_pkg::*;
#(
  parameter int NUM_IRQ     = NUM_IRQ_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int MIN_LOW     = MIN_LOW_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IRQ-1:0]       event_i,
  input  logic [NUM_IRQ-1:0]       mask_i,
  input  logic [NUM_IRQ-1:0]       eoi_i,
  input  logic                     clr_i,
  output logic [NUM_IRQ-1:0]       irq_o,
  output logic [NUM_IRQ*CNT_W-1:0] pend_cnt_o,
  output logic [NUM_IRQ-1:0]       overflow_o,
  output logic [NUM_IRQ-1:0]       timeout_o,
  output logic [NUM_IRQ-1:0]       spurious_o
);

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_chan
    irq_req_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .MIN_LOW     (MIN_LOW),
      .TIMEOUT     (TIMEOUT)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .event_i    (event_i[g]),
      .mask_i     (mask_i[g]),
      .eoi_i      (eoi_i[g]),
      .clr_i      (clr_i),
      .irq_o      (irq_o[g]),
      .pend_cnt_o (pend_cnt_o[g*CNT_W +: CNT_W]),
      .overflow_o (overflow_o[g]),
      .timeout_o  (timeout_o[g]),
      .spurious_o (spurious_o[g])
    );
  end

endmodule

// File: tb/tb_irq_requester.sv
// Bench for irq_requester: behavioural reference model, per-cycle compare, directed + random stimulus.
module tb_irq_requester;

  localparam int NUM_IRQ = 16;
  localparam int CNT_W   = 4;
  localparam int SYNC    = 2;
  localparam int MIN_LOW = 2;
  localparam int TIMEOUT = 1024;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_IRQ-1:0]       event_i, mask_i, eoi_i;
  logic                     clr_i;
  logic [NUM_IRQ-1:0]       irq_o, overflow_o, timeout_o, spurious_o;
  logic [NUM_IRQ*CNT_W-1:0] pend_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  irq_requester #(
    .NUM_IRQ(NUM_IRQ), .CNT_W(CNT_W), .SYNC_STAGES(SYNC),
    .MIN_LOW(MIN_LOW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .event_i(event_i), .mask_i(mask_i), .eoi_i(eoi_i),
    .clr_i(clr_i), .irq_o(irq_o), .pend_cnt_o(pend_cnt_o),
    .overflow_o(overflow_o), .timeout_o(timeout_o), .spurious_o(spurious_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [CNT_W-1:0] pend(input int ch);
    return pend_cnt_o[ch*CNT_W +: CNT_W];
  endfunction

  // Reference model: line level, pending count, remaining low-gap cycles,
  // cycles waited for EOI, and the history of sampled EOI values (index 0 newest).
  int m_cnt  [NUM_IRQ];
  bit m_irq  [NUM_IRQ];
  int m_gap  [NUM_IRQ];
  int m_wait [NUM_IRQ];
  bit m_hist [NUM_IRQ][SYNC+1];
  bit m_ovf  [NUM_IRQ];
  bit m_tmo  [NUM_IRQ];
  bit m_spur [NUM_IRQ];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        m_cnt[i] = 0; m_irq[i] = 0; m_gap[i] = 0; m_wait[i] = 0;
        m_ovf[i] = 0; m_tmo[i] = 0; m_spur[i] = 0;
        for (int k = 0; k <= SYNC; k++) m_hist[i][k] = 1;
      end
    end else begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        bit ack, acc, ovf_s, tmo_s, spur_s;
        int old_cnt;
        ack = m_hist[i][SYNC-1] && !m_hist[i][SYNC];
        acc = 0; ovf_s = 0; tmo_s = 0; spur_s = 0;
        old_cnt = m_cnt[i];
        if (m_irq[i]) begin
          if (ack) begin
            acc = 1; m_irq[i] = 0; m_gap[i] = MIN_LOW; m_wait[i] = 0;
          end else begin
            m_wait[i] = (m_wait[i] + 1 > TIMEOUT) ? TIMEOUT : m_wait[i] + 1;
            if (m_wait[i] == TIMEOUT) tmo_s = 1;
          end
        end else begin
          spur_s = ack;
          if (m_gap[i] > 0) m_gap[i]--;
          else if (old_cnt > 0 && !mask_i[i]) m_irq[i] = 1;
        end
        if (event_i[i] && !acc) begin
          if (old_cnt == CMAX) ovf_s = 1;
          else m_cnt[i] = old_cnt + 1;
        end else if (acc && !event_i[i]) begin
          m_cnt[i] = old_cnt - 1;
        end
        m_ovf[i]  = ovf_s  | (m_ovf[i]  & !clr_i);
        m_tmo[i]  = tmo_s  | (m_tmo[i]  & !clr_i);
        m_spur[i] = spur_s | (m_spur[i] & !clr_i);
        for (int k = SYNC; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][0] = eoi_i[i];
      end
    end
  end

  always @(negedge clk) begin
    logic [NUM_IRQ-1:0]       e_irq, e_ovf, e_tmo, e_spur;
    logic [NUM_IRQ*CNT_W-1:0] e_pend;
    for (int i = 0; i < NUM_IRQ; i++) begin
      e_irq[i]  = m_irq[i];
      e_ovf[i]  = m_ovf[i];
      e_tmo[i]  = m_tmo[i];
      e_spur[i] = m_spur[i];
      e_pend[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
    end
    check("model_irq",      64'(irq_o),      64'(e_irq));
    check("model_pend",     64'(pend_cnt_o), 64'(e_pend));
    check("model_overflow", 64'(overflow_o), 64'(e_ovf));
    check("model_timeout",  64'(timeout_o),  64'(e_tmo));
    check("model_spurious", 64'(spurious_o), 64'(e_spur));
  end

  initial begin
    rst = 1'b1; event_i = '0; mask_i = '0; eoi_i = '0; clr_i = 1'b0;
    cyc(3);
    check("reset_irq",   64'(irq_o), 64'd0);
    check("reset_pend",  64'(pend_cnt_o), 64'd0);
    check("reset_flags", 64'({overflow_o, timeout_o, spurious_o}), 64'd0);
    rst = 1'b0;
    cyc(2);

    // Single event on ch3, then one EOI.
    event_i[3] = 1'b1; cyc(1); event_i[3] = 1'b0;
    check("single_pend1", 64'(pend(3)), 64'd1);
    check("single_irq_lo", 64'(irq_o[3]), 64'd0);
    cyc(1);
    check("single_irq_hi", 64'(irq_o[3]), 64'd1);
    eoi_i[3] = 1'b1;
    cyc(2);
    check("single_irq_hold", 64'(irq_o[3]), 64'd1);
    cyc(1);
    check("single_irq_drop", 64'(irq_o[3]), 64'd0);
    check("single_pend0", 64'(pend(3)), 64'd0);
    eoi_i[3] = 1'b0;
    cyc(5);
    check("single_no_reassert", 64'(irq_o[3]), 64'd0);

    // Burst of three events on ch0 retired by three EOIs.
    event_i[0] = 1'b1; cyc(3); event_i[0] = 1'b0;
    check("burst_pend3", 64'(pend(0)), 64'd3);
    for (int k = 0; k < 3; k++) begin
      check("burst_irq_hi", 64'(irq_o[0]), 64'd1);
      eoi_i[0] = 1'b1; cyc(3);
      check("burst_irq_drop", 64'(irq_o[0]), 64'd0);
      check("burst_pend", 64'(pend(0)), 64'(2 - k));
      eoi_i[0] = 1'b0; cyc(2);
      check("burst_gap_low", 64'(irq_o[0]), 64'd0);
      cyc(4);
    end
    check("burst_idle", 64'(irq_o[0]), 64'd0);

    // Overflow on ch7.
    event_i[7] = 1'b1; cyc(15);
    check("ovf_pend15", 64'(pend(7)), 64'd15);
    check("ovf_not_yet", 64'(overflow_o[7]), 64'd0);
    cyc(1);
    check("ovf_set", 64'(overflow_o[7]), 64'd1);
    cyc(1); event_i[7] = 1'b0;
    clr_i = 1'b1; cyc(1); clr_i = 1'b0;
    check("ovf_cleared", 64'(overflow_o[7]), 64'd0);
    check("ovf_pend_kept", 64'(pend(7)), 64'd15);

    // Masked channel counts but does not request.
    mask_i[5] = 1'b1;
    event_i[5] = 1'b1; cyc(1); event_i[5] = 1'b0;
    cyc(3);
    check("mask_irq_lo", 64'(irq_o[5]), 64'd0);
    check("mask_pend1", 64'(pend(5)), 64'd1);
    mask_i[5] = 1'b0; cyc(1);
    check("unmask_irq_hi", 64'(irq_o[5]), 64'd1);

    // Timeout on ch2.
    event_i[2] = 1'b1; cyc(1); event_i[2] = 1'b0;
    cyc(1);
    check("tmo_irq_hi", 64'(irq_o[2]), 64'd1);
    cyc(TIMEOUT - 1);
    check("tmo_not_yet", 64'(timeout_o[2]), 64'd0);
    cyc(1);
    check("tmo_set", 64'(timeout_o[2]), 64'd1);
    check("tmo_irq_still_hi", 64'(irq_o[2]), 64'd1);

    // Spurious EOI on idle ch9.
    eoi_i[9] = 1'b1; cyc(4); eoi_i[9] = 1'b0;
    check("spur_set", 64'(spurious_o[9]), 64'd1);
    check("spur_pend", 64'(pend(9)), 64'd0);
    cyc(3);

    // Reset during ASSERT with EOI held high on ch1.
    event_i[1] = 1'b1; cyc(1); event_i[1] = 1'b0;
    cyc(1);
    check("rstmid_irq_hi", 64'(irq_o[1]), 64'd1);
    eoi_i[1] = 1'b1; cyc(1);
    #2 rst = 1'b1;
    #1;
    check("rstmid_irq_zero", 64'(irq_o), 64'd0);
    check("rstmid_pend_zero", 64'(pend_cnt_o), 64'd0);
    cyc(2); rst = 1'b0;
    cyc(6);
    check("rstmid_no_spur", 64'(spurious_o[1]), 64'd0);
    check("rstmid_irq_lo", 64'(irq_o[1]), 64'd0);
    eoi_i[1] = 1'b0;
    cyc(3);

    // Randomized traffic on all channels.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        event_i[i] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 31) == 0) mask_i[i] = ~mask_i[i];
        if ($urandom_range(0, 5) == 0)  eoi_i[i]  = ~eoi_i[i];
      end
      clr_i = ($urandom_range(0, 49) == 0);
      cyc(1);
    end
    event_i = '0; clr_i = 1'b0;
    cyc(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
